dallanma_denetleyici: RTL

Branch-resolution controller sitting between the fetch stage, the branch predictor (ongorucu) and the execute stage. Records every prediction issued at fetch into an in-flight queue, checks each execute-stage resolution against the oldest outstanding prediction, and on a mispredict issues a one-cycle fetch redirect, flushes the queue and holds fetch for a fixed penalty. Also keeps branch and mispredict statistics for performance counters.

---
 rtl/dallanma_denetleyici.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dallanma_denetleyici.sv
// dallanma_denetleyici
//   Branch-resolution controller between fetch, the branch predictor and
//   execute. Each prediction issued at fetch is recorded in a circular
//   in-flight queue. Each execute-stage resolution is checked against the
//   oldest outstanding prediction. A mispredict raises a one-cycle redirect,
//   flushes the queue and holds fetch for CEZA cycles. Branch and mispredict
//   totals are kept for the performance counters.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   getir_gecerli    : fetch presents a control-flow instruction
//   getir_ps         : PC of that instruction
//   ongoru_dallan    : predicted taken
//   ongoru_ps        : predicted target
//   yurut_gecerli    : execute resolves a control-flow instruction
//   yurut_ps         : PC of the resolved instruction
//   yurut_dallan     : actual taken outcome
//   yurut_dallan_ps  : actual target
//   getir_durdur     : fetch must hold; pushes are ignored while high
//   duzelt_gecerli   : one-cycle redirect strobe
//   duzelt_ps        : redirect PC, valid with duzelt_gecerli
//   dallanma_sayisi  : count of resolved branches
//   hatali_sayisi    : count of mispredicts, including sequence errors
//   sira_hata        : sticky flag set when a resolution has no matching head
module dallanma_denetleyici #(
  parameter int DERINLIK = 4,
  parameter int CEZA     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        getir_gecerli,
  input  logic [31:0] getir_ps,
  input  logic        ongoru_dallan,
  input  logic [31:0] ongoru_ps,
  input  logic        yurut_gecerli,
  input  logic [31:0] yurut_ps,
  input  logic        yurut_dallan,
  input  logic [31:0] yurut_dallan_ps,
  output logic        getir_durdur,
  output logic        duzelt_gecerli,
  output logic [31:0] duzelt_ps,
  output logic [31:0] dallanma_sayisi,
  output logic [31:0] hatali_sayisi,
  output logic        sira_hata
);

  localparam int AW = $clog2(DERINLIK);
  localparam int CW = $clog2(CEZA + 1);
  localparam logic [AW:0]   DOLU   = (AW + 1)'(DERINLIK);
  localparam logic [CW-1:0] CEZA_Y = CW'(CEZA);
  localparam logic [CW-1:0] BIR    = CW'(1);

  typedef enum logic {CALIS, TEMIZLE} durum_t;

  durum_t        durum, durum_sonraki;
  logic [CW-1:0] sayac, sayac_sonraki;

  // Queue storage is data only; validity is carried by the pointers/occupancy.
  logic [31:0] kuyruk_ps     [DERINLIK];
  logic        kuyruk_dallan [DERINLIK];
  logic [31:0] kuyruk_hedef  [DERINLIK];

  logic [AW-1:0] bas, son;
  logic [AW:0]   doluluk;

  logic calis, bos, coz, sira_hatasi, yon_hatasi, hedef_hatasi;
  logic hatali, dogru, ekle;

  // Resolution compare against the queue head
  always_comb begin
    calis        = (durum == CALIS);
    bos          = (doluluk == '0);
    coz          = calis & yurut_gecerli;
    sira_hatasi  = bos | (yurut_ps != kuyruk_ps[bas]);
    yon_hatasi   = (kuyruk_dallan[bas] != yurut_dallan);
    // Target only matters when both predicted and actual are taken.
    hedef_hatasi = kuyruk_dallan[bas] & yurut_dallan &
                   (kuyruk_hedef[bas] != yurut_dallan_ps);
    hatali       = coz & (sira_hatasi | yon_hatasi | hedef_hatasi);
    dogru        = coz & ~hatali;
    getir_durdur = (durum == TEMIZLE) | (doluluk == DOLU);
    // A push in the mispredict cycle is wrong-path and is dropped with the flush.
    ekle         = calis & getir_gecerli & ~getir_durdur & ~hatali;
  end

  // Controller FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      durum <= CALIS;
      sayac <= '0;
    end else begin
      durum <= durum_sonraki;
      sayac <= sayac_sonraki;
    end
  end

  // Controller FSM: next state; the penalty counter is loaded on entry and
  // the last TEMIZLE cycle is the one where it holds 1.
  always_comb begin
    durum_sonraki = durum;
    sayac_sonraki = sayac;
    case (durum)
      CALIS: begin
        if (hatali) begin
          durum_sonraki = TEMIZLE;
          sayac_sonraki = CEZA_Y;
        end
      end
      TEMIZLE: begin
        sayac_sonraki = sayac - BIR;
        if (sayac == BIR) durum_sonraki = CALIS;
      end
      default: durum_sonraki = CALIS;
    endcase
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || hatali) begin
      bas     <= '0;
      son     <= '0;
      doluluk <= '0;
    end else begin
      if (ekle)  son <= son + 1'b1;
      if (dogru) bas <= bas + 1'b1;
      doluluk <= doluluk + (AW + 1)'(ekle) - (AW + 1)'(dogru);
    end
  end

  // Queue entry write
  always_ff @(posedge clk) begin
    if (ekle) begin
      kuyruk_ps[son]     <= getir_ps;
      kuyruk_dallan[son] <= ongoru_dallan;
      kuyruk_hedef[son]  <= ongoru_ps;
    end
  end

  // Registered redirect, statistics and sticky sequence flag
  always_ff @(posedge clk) begin
    if (rst) begin
      duzelt_gecerli  <= 1'b0;
      duzelt_ps       <= '0;
      dallanma_sayisi <= '0;
      hatali_sayisi   <= '0;
      sira_hata       <= 1'b0;
    end else begin
      duzelt_gecerli <= hatali;
      if (hatali) begin
        duzelt_ps     <= yurut_dallan ? yurut_dallan_ps : yurut_ps + 32'd4;
        hatali_sayisi <= hatali_sayisi + 32'd1;
      end
      if (coz) dallanma_sayisi <= dallanma_sayisi + 32'd1;
      if (coz && sira_hatasi) sira_hata <= 1'b1;
    end
  end

endmodule
